// File: rtl/delay_pkg.sv
// Shared constants and address helper for the programmable delay line.
package delay_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 8;
    localparam int unsigned DEFAULT_MAX_DEPTH   = 90;
    localparam int unsigned DEFAULT_RESET_DELAY = 30;

    // Ring read address (wr - dly + 1) mod depth. Assumes wr < depth and
    // 1 <= dly <= depth, so one conditional subtract replaces a true modulo.
    function automatic int unsigned ring_rd_addr(input int unsigned wr,
                                                 input int unsigned dly,
                                                 input int unsigned depth);
        int unsigned t;
        t = wr + depth + 1 - dly;
        return (t >= depth) ? (t - depth) : t;
    endfunction

endpackage

// File: rtl/dl_ring_ram.sv
// History storage: one synchronous write port, one asynchronous read port.
module dl_ring_ram
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_MAX_DEPTH,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the accepted sample; contents are never reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_delay_line.sv
// Programmable delay line: D-stage shift advanced only by accepted samples,
// built on a circular buffer with a fill counter gating output validity.
module prog_delay_line
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned MAX_DEPTH   = DEFAULT_MAX_DEPTH,
    parameter int unsigned DLY_W       = $clog2(MAX_DEPTH + 1),
    parameter int unsigned RESET_DELAY = DEFAULT_RESET_DELAY
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data,
    input  logic [DLY_W-1:0] delay_sel,
    input  logic             delay_load,
    input  logic             flush,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             cfg_err,
    output logic [DLY_W-1:0] cur_delay
);

    localparam int unsigned AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int unsigned FW = $clog2(MAX_DEPTH + 1);

    logic [AW-1:0]    wr_ptr, wr_ptr_d, wr_addr, rd_addr;
    logic [FW-1:0]    fill, fill_d;
    logic [DLY_W-1:0] delay_d;
    logic [WIDTH-1:0] ram_rdata, out_d;
    logic             out_valid_d, cfg_err_d, load_ok, restart;

    dl_ring_ram #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (in_valid),
        .waddr (wr_addr),
        .wdata (data),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Next-state: load/flush restart the history, then an accepted sample shifts in.
    always_comb begin
        load_ok     = delay_load && (delay_sel != '0) && (32'(delay_sel) <= MAX_DEPTH);
        restart     = flush || load_ok;
        cfg_err_d   = delay_load && !load_ok;
        delay_d     = load_ok ? delay_sel : cur_delay;
        // A flushed history starts writing at slot 0.
        wr_addr     = flush ? '0 : wr_ptr;
        rd_addr     = AW'(ring_rd_addr(32'(wr_ptr), 32'(cur_delay), MAX_DEPTH));
        wr_ptr_d    = wr_ptr;
        fill_d      = fill;
        out_d       = out;
        out_valid_d = out_valid;

        if (restart) begin
            fill_d      = '0;
            out_d       = '0;
            out_valid_d = 1'b0;
            if (flush) begin
                wr_ptr_d = '0;
            end
        end

        if (in_valid) begin
            wr_ptr_d = (32'(wr_addr) == MAX_DEPTH - 1) ? '0 : wr_addr + AW'(1);
            if (restart) begin
                fill_d = FW'(1);
            end else if (32'(fill) < MAX_DEPTH) begin
                fill_d = fill + FW'(1);
            end
            if (32'(fill_d) >= 32'(delay_d)) begin
                out_valid_d = 1'b1;
                // D=1 needs the sample being written this edge, not the RAM slot.
                out_d       = (delay_d == DLY_W'(1)) ? data : ram_rdata;
            end else begin
                out_valid_d = 1'b0;
                out_d       = '0;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            fill      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
            cur_delay <= DLY_W'(RESET_DELAY);
        end else begin
            wr_ptr    <= wr_ptr_d;
            fill      <= fill_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            cfg_err   <= cfg_err_d;
            cur_delay <= delay_d;
        end
    end

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line: fixed vector table, directed
// corner sequences and randomized traffic against a sample-history model.
module tb_prog_delay_line;

    localparam int MD = 90;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] data;
    logic [6:0] delay_sel;
    logic       delay_load;
    logic       flush;
    logic [7:0] out;
    logic       out_valid;
    logic       cfg_err;
    logic [6:0] cur_delay;

    prog_delay_line dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .data       (data),
        .delay_sel  (delay_sel),
        .delay_load (delay_load),
        .flush      (flush),
        .out        (out),
        .out_valid  (out_valid),
        .cfg_err    (cfg_err),
        .cur_delay  (cur_delay)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: samples accepted since the last restart; output is the one D back.
    logic [7:0] hist[$];
    int         m_d;
    logic [7:0] m_out;
    logic       m_valid;
    logic       m_err;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic [6:0] sel;
        logic       ld;
        logic       fl;
        logic [7:0] eo;
        logic       ev;
        logic       ee;
        logic [6:0] edly;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_d     = 30;
        m_out   = 8'h00;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge(input logic iv, input logic [7:0] d, input logic [6:0] sel,
                              input logic ld, input logic fl);
        m_err = ld && (sel == 0 || int'(sel) > MD);
        if (fl || (ld && !m_err)) begin
            hist.delete();
            m_out   = 8'h00;
            m_valid = 1'b0;
        end
        if (ld && !m_err) m_d = int'(sel);
        if (iv) begin
            hist.push_back(d);
            if (hist.size() > MD) void'(hist.pop_front());
            if (hist.size() >= m_d) begin
                m_valid = 1'b1;
                m_out   = hist[hist.size() - m_d];
            end else begin
                m_valid = 1'b0;
                m_out   = 8'h00;
            end
        end
    endtask

    // Drive at the falling edge, clock once, land on the next falling edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic [6:0] sel,
                        input logic ld, input logic fl);
        in_valid   = iv;
        data       = d;
        delay_sel  = sel;
        delay_load = ld;
        flush      = fl;
        @(posedge clock);
        model_edge(iv, d, sel, ld, fl);
        @(negedge clock);
    endtask

    task automatic check_model(input string name);
        check(name, {15'd0, out, out_valid, cfg_err, cur_delay},
              {15'd0, m_out, m_valid, m_err, 7'(m_d)});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int accepted;
        logic iv;

        reset      = 1'b1;
        in_valid   = 1'b0;
        data       = 8'h00;
        delay_sel  = 7'd0;
        delay_load = 1'b0;
        flush      = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check("reset_state", {15'd0, out, out_valid, cfg_err, cur_delay},
              {15'd0, 8'h00, 1'b0, 1'b0, 7'd30});
        reset = 1'b0;

        // Table: short D=3 stream, gap hold, illegal loads, flush+load, D=1/D=2.
        tbl[0]  = '{1'b0, 8'h00, 7'd3,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 7'd3};
        tbl[1]  = '{1'b1, 8'h10, 7'd0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 7'd3};
        tbl[2]  = '{1'b1, 8'h20, 7'd0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 7'd3};
        tbl[3]  = '{1'b0, 8'h99, 7'd0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 7'd3};
        tbl[4]  = '{1'b1, 8'h30, 7'd0,  1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 7'd3};
        tbl[5]  = '{1'b1, 8'h40, 7'd0,  1'b1, 1'b0, 8'h20, 1'b1, 1'b1, 7'd3};
        tbl[6]  = '{1'b0, 8'h00, 7'd0,  1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 7'd3};
        tbl[7]  = '{1'b1, 8'hA5, 7'd1,  1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 7'd1};
        tbl[8]  = '{1'b1, 8'h3C, 7'd0,  1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 7'd1};
        tbl[9]  = '{1'b0, 8'h00, 7'd0,  1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 7'd1};
        tbl[10] = '{1'b1, 8'h07, 7'd91, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 7'd1};
        tbl[11] = '{1'b1, 8'h08, 7'd2,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 7'd2};
        tbl[12] = '{1'b1, 8'h09, 7'd0,  1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 7'd2};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].sel, tbl[i].ld, tbl[i].fl);
            check($sformatf("table[%0d]", i), {15'd0, out, out_valid, cfg_err, cur_delay},
                  {15'd0, tbl[i].eo, tbl[i].ev, tbl[i].ee, tbl[i].edly});
        end

        // Default delay 30 with a counting stream.
        do_reset();
        for (n = 1; n <= 40; n++) begin
            step(1'b1, 8'(n), 7'd0, 1'b0, 1'b0);
            check($sformatf("d30_sample%0d", n), {23'd0, out, out_valid},
                  {23'd0, (n >= 30) ? 8'(n - 29) : 8'h00, n >= 30});
        end

        // Mid-stream reload to 5: four empty outputs, then the first new sample.
        step(1'b0, 8'h00, 7'd5, 1'b1, 1'b0);
        check("load5_immediate", {15'd0, out, out_valid, cfg_err, cur_delay},
              {15'd0, 8'h00, 1'b0, 1'b0, 7'd5});
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 8'(100 + i), 7'd0, 1'b0, 1'b0);
            check($sformatf("load5_sample%0d", i), {23'd0, out, out_valid},
                  {23'd0, (i >= 5) ? 8'(100 + i - 4) : 8'h00, i >= 5});
        end

        // Illegal loads keep streaming and pulse cfg_err once.
        step(1'b1, 8'd110, 7'd0, 1'b1, 1'b0);
        check_model("bad_load0");
        check("bad_load0_err", {31'd0, cfg_err}, 32'd1);
        step(1'b1, 8'd111, 7'd0, 1'b0, 1'b0);
        check("bad_load0_err_clear", {31'd0, cfg_err}, 32'd0);
        check_model("bad_load0_after");
        step(1'b1, 8'd112, 7'd91, 1'b1, 1'b0);
        check_model("bad_load91");
        step(1'b1, 8'd113, 7'd0, 1'b0, 1'b0);
        check_model("bad_load91_after");

        // D=90 across pointer wrap with random gaps.
        step(1'b0, 8'h00, 7'd90, 1'b1, 1'b0);
        accepted = 0;
        for (int c = 0; c < 2000 && accepted < 300; c++) begin
            iv = ($urandom_range(0, 3) != 0);
            step(iv, 8'($urandom), 7'd0, 1'b0, 1'b0);
            if (iv) accepted++;
            check_model("d90_wrap");
        end
        check("d90_accepted_count", 32'(accepted), 32'd300);

        // Flush coincident with a sample at D=1.
        step(1'b0, 8'h00, 7'd1, 1'b1, 1'b0);
        step(1'b1, 8'h55, 7'd0, 1'b0, 1'b0);
        step(1'b1, 8'hA5, 7'd0, 1'b0, 1'b1);
        check("flush_d1", {23'd0, out, out_valid}, {23'd0, 8'hA5, 1'b1});

        // Reset between edges: outputs clear at once, refill from empty.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 1), 7'd0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_reset", {15'd0, out, out_valid, cfg_err, cur_delay},
              {15'd0, 8'h00, 1'b0, 1'b0, 7'd30});
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            step(1'b1, 8'(i + 50), 7'd0, 1'b0, 1'b0);
            check_model("refill");
        end

        // Random traffic with loads and flushes.
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 7'($urandom_range(0, 127)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
            check_model("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_delay_line.md
PROG_DELAY_LINE -- requirements
Module: prog_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits.
REQ-002 SHALL have parameter MAX_DEPTH, default 90, largest selectable delay in samples.
REQ-003 SHALL have parameter DLY_W, default $clog2(MAX_DEPTH+1), width of the delay-select field.
REQ-004 SHALL have parameter RESET_DELAY, default 30, delay in force after reset.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clock  input  1  rising-edge clock.
REQ-006 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port: in_valid  input  1  sample enable; data is accepted on this edge.
REQ-008 SHALL have port: data  input  WIDTH  input sample.
REQ-009 SHALL have port: delay_sel  input  DLY_W  requested delay in accepted samples.
REQ-010 SHALL have port: delay_load  input  1  one-cycle strobe that applies delay_sel.
REQ-011 SHALL have port: flush  input  1  one-cycle strobe that discards buffered history.
REQ-012 SHALL have port: out  output  WIDTH  delayed sample, registered.
REQ-013 SHALL have port: out_valid  output  1  out holds a genuine delayed sample.
REQ-014 SHALL have port: cfg_err  output  1  one-cycle pulse on a rejected delay_load.
REQ-015 SHALL have port: cur_delay  output  DLY_W  delay currently in force.

Function
REQ-016 SHALL behave as a D-stage shift register advanced only on edges with in_valid=1, with D=cur_delay.
  - After the edge accepting sample x_k: out = x_(k-D+1).
  - D=1 therefore gives out = x_k.
REQ-017 SHALL, with in_valid held high, present data sampled at cycle n on out after cycle n+D-1, i.e. D clocks of latency.
REQ-018 SHALL hold out, out_valid and all pointers unchanged on edges with in_valid=0.
REQ-019 SHALL store history in a MAX_DEPTH-entry circular buffer.
  - Write pointer wraps from MAX_DEPTH-1 to 0.
  - Read address = (wr_ptr - D + 1) mod MAX_DEPTH, computed without overflow at the wrap.
REQ-020 SHALL keep a fill counter of samples accepted since the last reset, flush or accepted load, saturating at MAX_DEPTH.
  - out_valid = 1 iff fill >= D.
  - out SHALL read 0 while out_valid = 0.
REQ-021 SHALL, on delay_load with 1 <= delay_sel <= MAX_DEPTH, set cur_delay = delay_sel at that edge, clear fill, drop out_valid and set out to 0 on the next cycle.
REQ-022 SHALL, on delay_load with delay_sel = 0 or delay_sel > MAX_DEPTH, leave cur_delay, fill and the output unchanged and pulse cfg_err for exactly one cycle.
REQ-023 SHALL, on flush, clear fill and wr_ptr, drive out = 0 and out_valid = 0, and keep cur_delay.
REQ-024 SHALL, when in_valid coincides with an accepted delay_load or with flush, write the sample as the first sample of the new history (fill = 1 afterwards).
REQ-025 SHALL, when flush and delay_load coincide, apply both: flush clears history and a legal load updates cur_delay.
REQ-026 SHALL, when D = MAX_DEPTH, produce correct output across the pointer wrap with no sample lost or duplicated.

Reset
REQ-027 SHALL, while reset is high, asynchronously force:
  - out = 0, out_valid = 0, cfg_err = 0;
  - cur_delay = RESET_DELAY;
  - wr_ptr = 0, fill = 0.
REQ-028 SHALL not require buffer memory contents to be cleared by reset; fill gating guarantees that stale data is never flagged valid.
REQ-029 SHALL accept a sample on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL take default WIDTH, MAX_DEPTH and RESET_DELAY constants, and a function computing the read address modulo MAX_DEPTH, from shared package delay_pkg.
REQ-031 SHALL implement the storage as sub-module dl_ring_ram, with one write port and one asynchronous read port, WIDTH x MAX_DEPTH.
REQ-032 SHALL allow the legacy fixed 30/45/60/90-sample lines to be replaced by four instances of this block with RESET_DELAY set accordingly.

Verification
REQ-033 SHALL cover: reset, in_valid=1 constant, data = cycle count 1,2,3,... -> out_valid rises after the 30th sample; out = 1 on that cycle and then increments by 1 every cycle.
REQ-034 SHALL cover: delay_load with delay_sel = 5 mid-stream -> out = 0 and out_valid = 0 for 4 accepted samples; on the 5th, out equals the first sample accepted after the load.
REQ-035 SHALL cover: delay_sel = 0 and delay_sel = 91 loads -> cfg_err high for one cycle each, cur_delay unchanged, and the output stream continues uninterrupted.
REQ-036 SHALL cover: D = 90, 300 samples with random in_valid gaps -> out always equals the sample accepted 89 enables earlier, including across the pointer wrap.
REQ-037 SHALL cover: flush coincident with in_valid (data = 0xA5), D = 1 -> out = 0xA5 and out_valid = 1 on the next cycle.
REQ-038 SHALL cover: reset asserted mid-stream between clock edges -> outputs are 0 immediately, cur_delay = 30, and refill restarts from empty.
